// File: rtl/pc_next_unit.sv
// pc_next_unit: fetch-stage PC register and next-PC sequencer.
// Forms branch and jump targets, issues fetch requests over valid/ready,
// and parks a redirect in pend_pc while fetch cannot advance so that the
// fetch address stays stable under back-pressure.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_pc4_i,
    input  logic [31:0]      br_offset_sl2_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_pc4_i,
    input  logic [25:0]      jump_index_i,
    input  logic             imem_ready_i,
    output logic             imem_valid_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             redirect_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Redirect request resolved for this cycle.
    typedef struct packed {
        logic        vld;
        logic [31:0] tgt;
    } redir_t;

    state_t             state_q, state_nxt;
    logic [31:0]        pc_q, pc_nxt;
    logic [31:0]        pc4_q, pc4_nxt;
    logic [31:0]        pend_q, pend_nxt;
    logic               redir_q, redir_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;

    logic               adv;
    logic [31:0]        br_tgt;
    logic [31:0]        j_tgt;
    redir_t             ev;
    logic [31:0]        hold_tgt;

    // Request is valid in every state except the single post-reset cycle.
    assign imem_valid_o = (state_q != BOOT);
    assign adv          = imem_valid_o & imem_ready_i & ~stall_i;

    // Target arithmetic; carries out of bit 31 are dropped.
    assign br_tgt = br_pc4_i + br_offset_sl2_i;
    assign j_tgt  = {jump_pc4_i[31:28], jump_index_i, 2'b00};

    // Branch is the older instruction, so it wins over a same-cycle jump.
    assign ev.vld = br_taken_i | jump_i;
    assign ev.tgt = br_taken_i ? br_tgt : j_tgt;

    // Leaving HOLD: a fresh redirect supersedes the parked one.
    assign hold_tgt = ev.vld ? ev.tgt : pend_q;

    // Next-state and next-register values.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        pc4_nxt   = pc4_q;
        pend_nxt  = pend_q;
        redir_nxt = 1'b0;
        cnt_nxt   = adv ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            BOOT: begin
                // No request outstanding, so a redirect can land directly.
                state_nxt = RUN;
                if (ev.vld) begin
                    pc_nxt    = ev.tgt;
                    pc4_nxt   = ev.tgt + 32'd4;
                    redir_nxt = 1'b1;
                end
            end
            RUN: begin
                if (ev.vld) begin
                    if (adv) begin
                        pc_nxt    = ev.tgt;
                        pc4_nxt   = ev.tgt + 32'd4;
                        redir_nxt = 1'b1;
                    end else begin
                        // Request still pending: keep pc_o stable, park target.
                        pend_nxt  = ev.tgt;
                        state_nxt = HOLD;
                    end
                end else if (adv) begin
                    pc_nxt  = pc4_q;
                    pc4_nxt = pc4_q + 32'd4;
                end
            end
            HOLD: begin
                if (adv) begin
                    pc_nxt    = hold_tgt;
                    pc4_nxt   = hold_tgt + 32'd4;
                    redir_nxt = 1'b1;
                    state_nxt = RUN;
                end else if (ev.vld) begin
                    pend_nxt = ev.tgt;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + 32'd4;
            pend_q  <= '0;
            redir_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            pc4_q   <= pc4_nxt;
            pend_q  <= pend_nxt;
            redir_q <= redir_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc4_q;
    assign redirect_o  = redir_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: inputs change and outputs are checked on
// the falling edge, state updates on the rising edge.
module tb_pc_next_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_pc4_i;
    logic [31:0] br_offset_sl2_i;
    logic        jump_i;
    logic [31:0] jump_pc4_i;
    logic [25:0] jump_index_i;
    logic        imem_ready_i;
    logic        imem_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        redirect_o;
    logic [31:0] fetch_cnt_o;

    int checks = 0;
    int errors = 0;

    pc_next_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .br_taken_i      (br_taken_i),
        .br_pc4_i        (br_pc4_i),
        .br_offset_sl2_i (br_offset_sl2_i),
        .jump_i          (jump_i),
        .jump_pc4_i      (jump_pc4_i),
        .jump_index_i    (jump_index_i),
        .imem_ready_i    (imem_ready_i),
        .imem_valid_o    (imem_valid_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .redirect_o      (redirect_o),
        .fetch_cnt_o     (fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                           input logic vld, input logic rd, input logic [31:0] cnt);
        chk({tag, ".pc"},    pc_o,                 pc);
        chk({tag, ".pc4"},   pc_plus4_o,           pc4);
        chk({tag, ".valid"}, {31'd0, imem_valid_o}, {31'd0, vld});
        chk({tag, ".redir"}, {31'd0, redirect_o},   {31'd0, rd});
        chk({tag, ".cnt"},   fetch_cnt_o,          cnt);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; br_pc4_i = '0;
        br_offset_sl2_i = '0; jump_i = 1'b0; jump_pc4_i = '0; jump_index_i = '0;
        imem_ready_i = 1'b1;

        // Reset and free-run
        tick(); tick();
        chk_all("reset", 32'h0, 32'h4, 1'b0, 1'b0, 32'd0);
        rst_i = 1'b0;
        tick();
        chk_all("boot_done", 32'h0, 32'h4, 1'b1, 1'b0, 32'd0);
        tick();
        chk_all("run1", 32'h4, 32'h8, 1'b1, 1'b0, 32'd1);
        tick();
        chk_all("run2", 32'h8, 32'hC, 1'b1, 1'b0, 32'd2);
        tick();
        chk_all("run3", 32'hC, 32'h10, 1'b1, 1'b0, 32'd3);

        // Branch to 0x100 as setup
        br_taken_i = 1'b1; br_pc4_i = 32'h0; br_offset_sl2_i = 32'h100;
        tick();
        br_taken_i = 1'b0;
        chk_all("to100", 32'h100, 32'h104, 1'b1, 1'b1, 32'd4);

        // Backward branch from 0x100: 0x104 + (-16) = 0xF4
        br_taken_i = 1'b1; br_pc4_i = 32'h104; br_offset_sl2_i = 32'hFFFF_FFF0;
        tick();
        br_taken_i = 1'b0;
        chk_all("br_back", 32'hF4, 32'hF8, 1'b1, 1'b1, 32'd5);
        tick();
        chk_all("br_after", 32'hF8, 32'hFC, 1'b1, 1'b0, 32'd6);

        // Same-cycle branch (0x200) and jump (0x3000_0100): branch wins
        br_taken_i = 1'b1; br_pc4_i = 32'h1FC; br_offset_sl2_i = 32'h4;
        jump_i = 1'b1; jump_pc4_i = 32'h3000_0008; jump_index_i = 26'h000_0040;
        tick();
        br_taken_i = 1'b0; jump_i = 1'b0;
        chk_all("br_wins", 32'h200, 32'h204, 1'b1, 1'b1, 32'd7);
        tick();
        chk_all("br_wins_next", 32'h204, 32'h208, 1'b1, 1'b0, 32'd8);

        // Queued redirects under back-pressure; newest (jump 0x800) wins
        imem_ready_i = 1'b0;
        br_taken_i = 1'b1; br_pc4_i = 32'h400; br_offset_sl2_i = 32'h0;
        tick();
        br_taken_i = 1'b0;
        chk_all("hold1", 32'h204, 32'h208, 1'b1, 1'b0, 32'd8);
        tick();
        chk_all("hold2", 32'h204, 32'h208, 1'b1, 1'b0, 32'd8);
        jump_i = 1'b1; jump_pc4_i = 32'h0000_0004; jump_index_i = 26'h000_0200;
        tick();
        jump_i = 1'b0;
        chk_all("hold3", 32'h204, 32'h208, 1'b1, 1'b0, 32'd8);
        imem_ready_i = 1'b1;
        tick();
        chk_all("hold_rel", 32'h800, 32'h804, 1'b1, 1'b1, 32'd9);
        tick();
        chk_all("hold_after", 32'h804, 32'h808, 1'b1, 1'b0, 32'd10);

        // Stall freezes everything for three cycles
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("stall", 32'h804, 32'h808, 1'b1, 1'b0, 32'd10);
        end
        stall_i = 1'b0;
        tick();
        chk_all("stall_rel", 32'h808, 32'h80C, 1'b1, 1'b0, 32'd11);

        // PC wrap at the top of the address space
        br_taken_i = 1'b1; br_pc4_i = 32'hFFFF_FFF8; br_offset_sl2_i = 32'h4;
        tick();
        br_taken_i = 1'b0;
        chk_all("to_top", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 32'd12);
        tick();
        chk_all("wrap", 32'h0, 32'h4, 1'b1, 1'b0, 32'd13);

        // Reset while a redirect is parked discards it
        imem_ready_i = 1'b0;
        br_taken_i = 1'b1; br_pc4_i = 32'h400; br_offset_sl2_i = 32'h0;
        tick();
        br_taken_i = 1'b0;
        chk_all("hold_pre_rst", 32'h0, 32'h4, 1'b1, 1'b0, 32'd13);
        imem_ready_i = 1'b1; rst_i = 1'b1;
        tick();
        chk_all("rst_hold", 32'h0, 32'h4, 1'b0, 1'b0, 32'd0);
        rst_i = 1'b0;
        tick();
        chk_all("rst_boot", 32'h0, 32'h4, 1'b1, 1'b0, 32'd0);
        tick();
        chk_all("rst_run", 32'h4, 32'h8, 1'b1, 1'b0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
